redmule_ldst_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one TCDM initiator port between the three load sources (X=0, W=1, Y=2) and the Z store source (3).
- Sits between the stream-in/stream-out units and the ECC/deduplication stage of the streamer. It is an alternative to the fixed load/store and source multiplexing.
- Tracks outstanding reads in an in-order ID FIFO and routes each read response back to the source that issued it.

---
 rtl/redmule_ldst_arbiter_pkg.sv | 17 +
 rtl/redmule_arb_id_fifo.sv | 77 +++++++
 rtl/redmule_ldst_arbiter.sv | 179 +++++++++++++++++
 tb/tb_redmule_ldst_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_ldst_arbiter_pkg.sv
// Shared constants and configuration types for the RedMulE load/store arbiter.
// The arbiter config travels inside the streamer control struct.
package redmule_ldst_arbiter_pkg;

  localparam int unsigned ArbNbSrc   = 4;
  localparam int unsigned ArbSrcX    = 0;
  localparam int unsigned ArbSrcW    = 1;
  localparam int unsigned ArbSrcY    = 2;
  localparam int unsigned ArbSrcZ    = 3;
  localparam int unsigned ArbWeightW = 4;

  typedef struct packed {
    logic [ArbNbSrc*ArbWeightW-1:0] weights;
    logic                           enable;
  } arb_cfg_t;

endpackage

// File: rtl/redmule_arb_id_fifo.sv
// In-order FIFO of source IDs for reads in flight; wrap-around pointers, DEPTH is a power of two.
module redmule_arb_id_fifo
  import redmule_ldst_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CNTW = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [IDW-1:0]  id_i,
  output logic [IDW-1:0]  head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNTW-1:0] count_o
);

  logic [IDW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == CNTW'(DEPTH));
  assign empty_o   = (cnt_q == {CNTW{1'b0}});
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok_s = push_i && (!full_o || pop_i) && !clear_i;
  assign pop_ok_s  = pop_i && !empty_o && !clear_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = {PW{1'b0}};
      rd_d  = {PW{1'b0}};
      cnt_d = {CNTW{1'b0}};
    end else begin
      wr_d = push_ok_s ? wr_q + PW'(1) : wr_q;
      rd_d = pop_ok_s  ? rd_q + PW'(1) : rd_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CNTW'(1);
        2'b01:   cnt_d = cnt_q - CNTW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CNTW{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // ID storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {IDW{1'b0}};
    end else if (push_ok_s) begin
      mem_q[wr_q] <= id_i;
    end
  end

endmodule

// File: rtl/redmule_ldst_arbiter.sv
// Weighted round-robin arbiter sharing one TCDM port between the X/W/Y loads and the Z store,
// with in-order routing of read responses back to the issuing source.
module redmule_ldst_arbiter
  import redmule_ldst_arbiter_pkg::*;
#(
  parameter int unsigned NB_SRC          = ArbNbSrc,
  parameter int unsigned DW              = 288,
  parameter int unsigned AW              = 32,
  parameter int unsigned WW              = ArbWeightW,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [NB_SRC*WW-1:0]   weights_i,
  input  logic [NB_SRC-1:0]      req_i,
  input  logic [NB_SRC-1:0]      wen_i,
  input  logic [NB_SRC*AW-1:0]   add_i,
  input  logic [NB_SRC*DW-1:0]   data_i,
  input  logic [NB_SRC*DW/8-1:0] be_i,
  output logic [NB_SRC-1:0]      gnt_o,
  output logic [NB_SRC-1:0]      r_valid_o,
  output logic [DW-1:0]          r_data_o,
  output logic                   tcdm_req_o,
  input  logic                   tcdm_gnt_i,
  output logic                   tcdm_wen_o,
  output logic [AW-1:0]          tcdm_add_o,
  output logic [DW-1:0]          tcdm_data_o,
  output logic [DW/8-1:0]        tcdm_be_o,
  input  logic                   tcdm_r_valid_i,
  input  logic [DW-1:0]          tcdm_r_data_i,
  output logic                   busy_o,
  output logic [CntW-1:0]        outstanding_o,
  output logic                   err_o
);

  localparam int unsigned IdW = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
  localparam int unsigned BW  = DW / 8;
  localparam logic [WW-1:0] CntOne = WW'(1);
  localparam logic [WW-1:0] CntMax = {WW{1'b1}};

  logic [IdW-1:0]    ptr_q, ptr_d, sel_q, sel_d, sel_s, head_s;
  logic [WW-1:0]     cnt_q, cnt_d, w_raw_s, w_eff_s;
  logic              lock_q, lock_d, err_q, err_d;
  logic [NB_SRC-1:0] elig_s, gnt_s, r_valid_s;
  logic              req_valid_s, hs_s, push_s, pop_s, full_s, empty_s, full_eff_s;
  logic [CntW-1:0]   count_s;

  assign pop_s      = tcdm_r_valid_i && !empty_s;
  // A slot freed by this cycle's response is immediately reusable by a read.
  assign full_eff_s = full_s && !pop_s;
  assign w_raw_s    = weights_i[ptr_q*WW +: WW];
  assign w_eff_s    = (w_raw_s == {WW{1'b0}}) ? CntOne : w_raw_s;

  // Per-source eligibility.
  always_comb begin
    elig_s = {NB_SRC{1'b0}};
    for (int i = 0; i < NB_SRC; i++) begin
      elig_s[i] = req_i[i] && enable_i && !(wen_i[i] && full_eff_s);
    end
  end

  // Source selection: locked source, else current pointer within quota, else next in cyclic order.
  always_comb begin
    sel_s       = ptr_q;
    req_valid_s = 1'b0;
    if (lock_q) begin
      sel_s       = sel_q;
      req_valid_s = 1'b1;
    end else if (elig_s[ptr_q] && (cnt_q < w_eff_s)) begin
      sel_s       = ptr_q;
      req_valid_s = 1'b1;
    end else begin
      // Scanned from the far end so the nearest eligible index is assigned last.
      for (int k = NB_SRC; k >= 1; k--) begin
        if (elig_s[(int'(ptr_q) + k) % NB_SRC]) begin
          sel_s       = IdW'((int'(ptr_q) + k) % NB_SRC);
          req_valid_s = 1'b1;
        end
      end
    end
  end

  assign hs_s        = req_valid_s && tcdm_gnt_i;
  assign push_s      = hs_s && wen_i[sel_s];
  assign tcdm_req_o  = req_valid_s;
  assign tcdm_wen_o  = wen_i[sel_s];
  assign tcdm_add_o  = add_i[sel_s*AW +: AW];
  assign tcdm_data_o = data_i[sel_s*DW +: DW];
  assign tcdm_be_o   = be_i[sel_s*BW +: BW];

  // Zero-latency grant and one-hot response routing.
  always_comb begin
    gnt_s     = {NB_SRC{1'b0}};
    r_valid_s = {NB_SRC{1'b0}};
    if (req_valid_s) begin
      gnt_s[sel_s] = tcdm_gnt_i;
    end else begin
      gnt_s = {NB_SRC{1'b0}};
    end
    if (pop_s) begin
      r_valid_s[head_s] = 1'b1;
    end else begin
      r_valid_s = {NB_SRC{1'b0}};
    end
  end

  assign gnt_o         = gnt_s;
  assign r_valid_o     = r_valid_s;
  assign r_data_o      = tcdm_r_data_i;
  assign outstanding_o = count_s;
  assign busy_o        = req_valid_s || (count_s != {CntW{1'b0}});
  assign err_o         = err_q;

  // Arbitration state next-state.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    sel_d  = sel_q;
    err_d  = tcdm_r_valid_i && empty_s;
    if (clear_i) begin
      ptr_d  = {IdW{1'b0}};
      cnt_d  = {WW{1'b0}};
      lock_d = 1'b0;
      sel_d  = {IdW{1'b0}};
      err_d  = 1'b0;
    end else if (req_valid_s && !tcdm_gnt_i) begin
      lock_d = 1'b1;
      sel_d  = sel_s;
    end else if (hs_s) begin
      lock_d = 1'b0;
      if (sel_s == ptr_q) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end else begin
        ptr_d = sel_s;
        cnt_d = CntOne;
      end
    end else begin
      lock_d = lock_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= {IdW{1'b0}};
      cnt_q  <= {WW{1'b0}};
      lock_q <= 1'b0;
      sel_q  <= {IdW{1'b0}};
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  redmule_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .IDW   (IdW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .id_i    (sel_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

endmodule

// File: tb/tb_redmule_ldst_arbiter.sv
// Self-checking bench for redmule_ldst_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_redmule_ldst_arbiter;

  localparam int NB = 4, DW = 288, AW = 32, WW = 4, MO = 4, CW = 3, BW = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, enable, tgnt, twen, treq, tr_valid, busy, err;
  logic [NB*WW-1:0] weights;
  logic [NB-1:0]    req, wen, gnt, rvalid;
  logic [NB*AW-1:0] add;
  logic [NB*DW-1:0] data;
  logic [NB*BW-1:0] be;
  logic [DW-1:0]    rdata, tdata, tr_data;
  logic [AW-1:0]    tadd;
  logic [BW-1:0]    tbe;
  logic [CW-1:0]    outst;

  redmule_ldst_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .weights_i(weights),
    .req_i(req), .wen_i(wen), .add_i(add), .data_i(data), .be_i(be),
    .gnt_o(gnt), .r_valid_o(rvalid), .r_data_o(rdata),
    .tcdm_req_o(treq), .tcdm_gnt_i(tgnt), .tcdm_wen_o(twen), .tcdm_add_o(tadd),
    .tcdm_data_o(tdata), .tcdm_be_o(tbe), .tcdm_r_valid_i(tr_valid), .tcdm_r_data_i(tr_data),
    .busy_o(busy), .outstanding_o(outst), .err_o(err)
  );

  int checks = 0, errors = 0;

  // Reference model state
  int m_ptr, m_cnt, m_lsel;
  bit m_lock, m_err;
  int m_q[$];

  // Outputs observed by the last step
  logic [NB-1:0] o_gnt, o_rvalid;
  logic o_err, o_req, o_wen, o_busy;
  logic [AW-1:0] o_add;
  logic [CW-1:0] o_out;
  logic [DW-1:0] o_rdata;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_lsel = 0; m_lock = 0; m_err = 0;
    m_q.delete();
  endtask

  // Inputs set after a negedge; compare mid-cycle, advance the model, move to the next negedge.
  task automatic step();
    int sel, w;
    bit found, pop, full;
    logic [NB-1:0] eg, e_gnt, e_rv;
    #2;
    pop  = tr_valid && (m_q.size() > 0);
    full = (m_q.size() == MO) && !pop;
    for (int i = 0; i < NB; i++) eg[i] = req[i] && enable && !(wen[i] && full);
    w = int'(weights[m_ptr*WW +: WW]);
    if (w == 0) w = 1;
    found = 0; sel = m_ptr;
    if (m_lock) begin found = 1; sel = m_lsel; end
    else if (eg[m_ptr] && m_cnt < w) begin found = 1; sel = m_ptr; end
    else for (int k = 1; k <= NB; k++)
      if (!found && eg[(m_ptr + k) % NB]) begin found = 1; sel = (m_ptr + k) % NB; end
    e_gnt = '0; if (found && tgnt) e_gnt[sel] = 1'b1;
    e_rv  = '0; if (pop) e_rv[m_q[0]] = 1'b1;
    chk("tcdm_req", treq, found);
    chk("gnt", gnt, e_gnt);
    chk("r_valid", rvalid, e_rv);
    if (pop) chk("r_data", rdata, tr_data);
    if (found) begin
      chk("tcdm_wen", twen, wen[sel]);
      chk("tcdm_add", tadd, add[sel*AW +: AW]);
      chk("tcdm_data", tdata, data[sel*DW +: DW]);
      chk("tcdm_be", tbe, be[sel*BW +: BW]);
    end
    chk("outstanding", outst, m_q.size());
    chk("busy", busy, found || m_q.size() != 0);
    chk("err", err, m_err);
    o_gnt = gnt; o_rvalid = rvalid; o_err = err; o_req = treq; o_wen = twen;
    o_busy = busy; o_add = tadd; o_out = outst; o_rdata = rdata;
    if (clear) model_reset();
    else begin
      m_err = tr_valid && m_q.size() == 0;
      if (pop) void'(m_q.pop_front());
      if (found && !tgnt) begin m_lock = 1; m_lsel = sel; end
      else if (found && tgnt) begin
        m_lock = 0;
        if (sel == m_ptr) begin if (m_cnt < 15) m_cnt++; end
        else begin m_ptr = sel; m_cnt = 1; end
        if (wen[sel]) m_q.push_back(sel);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    clear = 0; enable = 1; tgnt = 1; tr_valid = 0; req = '0; wen = '0;
  endtask

  task automatic do_clear();
    idle_in(); clear = 1; step(); clear = 0;
  endtask

  // New random payload for a source unless it is still waiting for its grant.
  task automatic rnd_in();
    for (int i = 0; i < NB; i++) begin
      if (!(req[i] && !o_gnt[i])) begin
        req[i] = ($urandom_range(0, 99) < 60);
        wen[i] = (i != NB - 1);
        add[i*AW +: AW] = $urandom;
        for (int c = 0; c < 9; c++) data[i*DW + c*32 +: 32] = $urandom;
        be[i*BW +: 32] = $urandom;
        be[i*BW + 32 +: 4] = 4'($urandom_range(0, 15));
      end
    end
    enable   = ($urandom_range(0, 99) < 90);
    tgnt     = ($urandom_range(0, 99) < 70);
    tr_valid = ($urandom_range(0, 99) < 40);
    for (int c = 0; c < 9; c++) tr_data[c*32 +: 32] = $urandom;
    clear    = ($urandom_range(0, 99) < 1);
  endtask

  initial begin
    logic [NB-1:0] seq[8];
    logic [DW-1:0] d0, d1, d2;
    rst_n = 0; idle_in(); weights = '0; add = '0; data = '0; be = '0; tr_data = '0;
    o_gnt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_gnt", gnt, 0); chk("rst_rvalid", rvalid, 0); chk("rst_req", treq, 0);
    chk("rst_busy", busy, 0); chk("rst_outst", outst, 0); chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NB; i++) add[i*AW +: AW] = 32'h1000_0000 + 32'(i);

    // Equal weights, all writing: strict rotation
    weights = 16'h1111; req = 4'b1111; wen = 4'b0000;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int j = 0; j < 8; j++) begin step(); chk("t1_gnt_seq", o_gnt, seq[j]); end

    // X weight 3 vs Z weight 1
    do_clear();
    weights = 16'h1113; req = 4'b1001; wen = 4'b0000;
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    for (int j = 0; j < 8; j++) begin step(); chk("t2_wrr_seq", o_gnt, seq[j]); end
    weights = 16'h1101; req = 4'b0010;
    for (int j = 0; j < 4; j++) begin step(); chk("t2_w0_gnt", o_gnt, 4'b0010); end

    // Stalled X read stays locked while Z waits
    do_clear();
    weights = 16'h1111; req = 4'b1001; wen = 4'b0001; tgnt = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t3_req_hold", o_req, 1); chk("t3_add_hold", o_add, 32'h1000_0000);
      chk("t3_wen_hold", o_wen, 1); chk("t3_no_gnt", o_gnt, 0);
    end
    tgnt = 1; step(); chk("t3_x_gnt", o_gnt, 4'b0001);
    req = 4'b1000; step(); chk("t3_z_gnt", o_gnt, 4'b1000);
    req = 4'b0000; tr_valid = 1; step(); tr_valid = 0;

    // FIFO full: reads masked, writes proceed, pop frees a slot in the same cycle
    do_clear();
    req = 4'b0010; wen = 4'b0111;
    for (int j = 0; j < 4; j++) step();
    req = 4'b1010; step();
    chk("t4_z_gnt_full", o_gnt, 4'b1000); chk("t4_outst_full", o_out, 3'd4);
    req = 4'b0010; tr_valid = 1; step();
    chk("t4_rvalid_w", o_rvalid, 4'b0010); chk("t4_gnt_on_pop", o_gnt, 4'b0010);
    req = 4'b0000;
    for (int j = 0; j < 4; j++) step();
    tr_valid = 0; step();

    // In-order response routing X, Y, X
    do_clear();
    wen = 4'b0111;
    req = 4'b0001; step(); req = 4'b0100; step(); req = 4'b0001; step(); req = 4'b0000;
    step(); step();
    d0 = {9{32'hA5A5_0001}}; d1 = {9{32'h5A5A_0002}}; d2 = {9{32'hC3C3_0003}};
    tr_valid = 1;
    tr_data = d0; step(); chk("t5_rv0", o_rvalid, 4'b0001); chk("t5_rd0", o_rdata, d0);
    tr_data = d1; step(); chk("t5_rv1", o_rvalid, 4'b0100); chk("t5_rd1", o_rdata, d1);
    tr_data = d2; step(); chk("t5_rv2", o_rvalid, 4'b0001); chk("t5_rd2", o_rdata, d2);

    // Unexpected response
    step(); chk("t6_rvalid_zero", o_rvalid, 0);
    tr_valid = 0; step(); chk("t6_err_pulse", o_err, 1);
    step(); chk("t6_err_clear", o_err, 0);

    // Clear mid-burst
    for (int j = 0; j < 30; j++) begin rnd_in(); clear = 0; step(); end
    rnd_in(); clear = 1; step();
    idle_in(); step(); chk("t7_clr_outst", o_out, 0); chk("t7_clr_busy", o_busy, 0);
    req = 4'b0110; wen = 4'b0110; step(); chk("t7_clr_next", o_gnt, 4'b0010);

    // Reset mid-burst
    for (int j = 0; j < 30; j++) begin rnd_in(); clear = 0; step(); end
    idle_in(); rst_n = 0; #2;
    chk("t8_rst_req", treq, 0); chk("t8_rst_gnt", gnt, 0); chk("t8_rst_outst", outst, 0);
    chk("t8_rst_busy", busy, 0); chk("t8_rst_err", err, 0);
    model_reset(); o_gnt = '0;
    @(negedge clk); rst_n = 1;
    req = 4'b1100; wen = 4'b0100; step(); chk("t8_rst_next", o_gnt, 4'b0100);

    // Random traffic
    for (int j = 0; j < 3000; j++) begin
      if (j % 150 == 0) weights = 16'($urandom);
      rnd_in();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
